wavegen_sequencer: RTL and testbench

- Scheduler that drives the waveform generator's select inputs (wave_sel, freq_sel, amplitude_sel, phase_sel) from a small programmable scenario table.
- Each entry holds one setting for a fixed number of waveform periods; changes occur only on a period boundary (generator counter carry-out), so no partial-period glitches reach the DDS output.
- Sits between the board/host configuration logic and the generator top.

---
 rtl/wavegen_sequencer_if.sv | 35 +++
 rtl/wavegen_sequencer.sv | 169 ++++++++++++++++
 tb/tb_wavegen_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wavegen_sequencer_if.sv
// Control/status bundle between host configuration logic, the scenario
// sequencer and the waveform generator select inputs.
interface wavegen_sequencer_if #(
  parameter int unsigned AW      = 3,
  parameter int unsigned DWELL_W = 8
);
  // host configuration and sequence control
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [10+DWELL_W-1:0] cfg_data;
  logic                  start;
  logic                  stop;
  logic                  loop;
  logic [AW-1:0]         last_idx;
  // generator period boundary
  logic                  cnt_co;
  // generator selects and status
  logic [2:0]            wave_sel;
  logic [2:0]            freq_sel;
  logic [1:0]            amplitude_sel;
  logic [1:0]            phase_sel;
  logic                  busy;
  logic [AW-1:0]         cur_idx;
  logic                  done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop, loop, last_idx, cnt_co,
    input  wave_sel, freq_sel, amplitude_sel, phase_sel, busy, cur_idx, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop, loop, last_idx, cnt_co,
    output wave_sel, freq_sel, amplitude_sel, phase_sel, busy, cur_idx, done
  );
endinterface

// File: rtl/wavegen_sequencer.sv
// Scenario sequencer for the waveform generator: steps through a small
// programmable table, holding each entry for its dwell count of generator
// periods, and only ever switches selects on a cnt_co period boundary.
// Build option: define WAVESEQ_LOOP_EN to honour the loop input (restart at
// entry 0 after last_idx); otherwise every sequence is one-shot.
module wavegen_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned DWELL_W = 8
) (
  input logic               clk,
  input logic               rst,
  wavegen_sequencer_if.slave bus
);

  localparam int unsigned EW = 10 + DWELL_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           wave_q, wave_d;
  logic [2:0]           freq_q, freq_d;
  logic [1:0]           amp_q, amp_d;
  logic [1:0]           phase_q, phase_d;
  logic [AW-1:0]        cur_idx_q, cur_idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [EW-1:0]        table_q [DEPTH];
  logic [EW-1:0]        table_d [DEPTH];

  logic                 loop_en;
  logic [AW-1:0]        lim_idx;
  logic                 ld;
  logic [AW-1:0]        ld_idx;
  logic [EW-1:0]        ent;
  logic [DWELL_W-1:0]   ent_dwell;

`ifdef WAVESEQ_LOOP_EN
  assign loop_en = bus.loop;
`else
  assign loop_en = 1'b0;
  logic unused_loop;
  assign unused_loop = bus.loop;
`endif

  // Out-of-range last_idx saturates to the final table entry.
  assign lim_idx = (32'(bus.last_idx) >= DEPTH) ? AW'(DEPTH - 1) : bus.last_idx;

  // Table writes are accepted only while idle and only for addresses in range.
  always_comb begin
    table_d = table_q;
    if (bus.cfg_we && (state_q == S_IDLE) && (32'(bus.cfg_addr) < DEPTH)) begin
      table_d[bus.cfg_addr] = bus.cfg_data;
    end
  end

  // Next-state logic: stop beats a period boundary, which beats start.
  always_comb begin
    state_d   = state_q;
    wave_d    = wave_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    phase_d   = phase_q;
    cur_idx_d = cur_idx_q;
    dwell_d   = dwell_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    ld_idx    = '0;

    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          if (bus.cnt_co) begin
            ld      = 1'b1;
            ld_idx  = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.cnt_co) begin
            if (dwell_q > DWELL_W'(1)) begin
              dwell_d = dwell_q - DWELL_W'(1);
            end else if (cur_idx_q < lim_idx) begin
              ld     = 1'b1;
              ld_idx = cur_idx_q + AW'(1);
            end else if (loop_en) begin
              ld     = 1'b1;
              ld_idx = '0;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Entry fields land on the same edge that sampled the boundary.
    ent       = table_q[ld_idx];
    ent_dwell = ent[10 +: DWELL_W];
    if (ld) begin
      wave_d    = ent[2:0];
      freq_d    = ent[5:3];
      amp_d     = ent[7:6];
      phase_d   = ent[9:8];
      cur_idx_d = ld_idx;
      dwell_d   = (ent_dwell == '0) ? DWELL_W'(1) : ent_dwell;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Scenario table storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_q <= '{default: '0};
    end else begin
      table_q <= table_d;
    end
  end

  // Sequencer FSM with registered selects and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wave_q    <= '0;
      freq_q    <= '0;
      amp_q     <= '0;
      phase_q   <= '0;
      cur_idx_q <= '0;
      dwell_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wave_q    <= wave_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      phase_q   <= phase_d;
      cur_idx_q <= cur_idx_d;
      dwell_q   <= dwell_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.wave_sel      = wave_q;
  assign bus.freq_sel      = freq_q;
  assign bus.amplitude_sel = amp_q;
  assign bus.phase_sel     = phase_q;
  assign bus.cur_idx       = cur_idx_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_wavegen_sequencer.sv
// Scoreboard bench for wavegen_sequencer: stimulus queues the hand-computed
// state expected after each boundary/stop, a monitor pops and compares.
module tb_wavegen_sequencer;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned DWELL_W = 8;

  // entry = {dwell, phase, amp, freq, wave}
  localparam logic [17:0] E0   = {8'd2, 2'd0, 2'd1, 3'd6, 3'd3};
  localparam logic [17:0] E1   = {8'd1, 2'd0, 2'd0, 3'd7, 3'd0};
  localparam logic [17:0] E2   = {8'd3, 2'd0, 2'd1, 3'd7, 3'd5};
  localparam logic [17:0] E1B  = {8'd5, 2'd3, 2'd3, 3'd1, 3'd7};
  localparam logic [17:0] E1Z  = {8'd0, 2'd3, 2'd2, 3'd4, 3'd2};
  localparam logic [17:0] ZERO = '0;

  typedef struct {
    string         tag;
    logic [9:0]    sel;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wavegen_sequencer_if #(.AW(AW), .DWELL_W(DWELL_W)) bus ();

  wavegen_sequencer #(.DEPTH(DEPTH), .AW(AW), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  function automatic exp_t mk(string tag, logic [17:0] ent, logic [AW-1:0] idx,
                              logic busy, logic done);
    exp_t e;
    e.tag  = tag;
    e.sel  = ent[9:0];
    e.idx  = idx;
    e.busy = busy;
    e.done = done;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: a sampled boundary or stop means the DUT presents a new state.
  initial begin
    exp_t e;
    logic trig;
    logic [9:0] got_sel;
    forever begin
      @(posedge clk);
      trig = !rst && (bus.cnt_co || bus.stop);
      @(negedge clk);
      if (trig) begin
        tests++;
        got_sel = {bus.phase_sel, bus.amplitude_sel, bus.freq_sel, bus.wave_sel};
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: no expectation queued (sel=%h idx=%0d)",
                   got_sel, bus.cur_idx);
        end else begin
          e = sb.pop_front();
          if (got_sel !== e.sel || bus.cur_idx !== e.idx ||
              bus.busy !== e.busy || bus.done !== e.done) begin
            fails++;
            $display("FAIL %s: got sel=%h idx=%0d busy=%b done=%b expected sel=%h idx=%0d busy=%b done=%b",
                     e.tag, got_sel, bus.cur_idx, bus.busy, bus.done,
                     e.sel, e.idx, e.busy, e.done);
          end
        end
      end
    end
  end

  // Count every cycle done is high, so a stretched pulse is visible.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) done_cnt++;
  end

  task automatic wr(input logic [AW-1:0] a, input logic [17:0] d);
    @(posedge clk); #2;
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    @(posedge clk); #2;
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_p();
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
  endtask

  task automatic co(input exp_t e);
    repeat (15) @(posedge clk);
    #2;
    sb.push_back(e);
    bus.cnt_co = 1'b1;
    @(posedge clk); #2 bus.cnt_co = 1'b0;
  endtask

  task automatic stop_p(input exp_t e);
    @(posedge clk); #2;
    sb.push_back(e);
    bus.stop = 1'b1;
    @(posedge clk); #2 bus.stop = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    fails++;
    tests++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    bus.last_idx = '0; bus.cnt_co = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_sel", {bus.phase_sel, bus.amplitude_sel, bus.freq_sel, bus.wave_sel}, 0);
    chk("reset_status", {bus.busy, bus.cur_idx, bus.done}, 0);

    wr(3'd0, E0); wr(3'd1, E1); wr(3'd2, E2);
    bus.last_idx = 3'd2;

    // one-shot: dwell 2,1,3 then done on the 7th boundary
    start_p();
    co(mk("r1_p1", E0, 0, 1, 0));
    co(mk("r1_p2", E0, 0, 1, 0));
    co(mk("r1_p3", E1, 1, 1, 0));
    co(mk("r1_p4", E2, 2, 1, 0));
    co(mk("r1_p5", E2, 2, 1, 0));
    co(mk("r1_p6", E2, 2, 1, 0));
    co(mk("r1_p7", E2, 2, 0, 1));
    exp_done = 1;
    settle();
    chk("r1_done_pulses", done_cnt, exp_done);

    // loop requested
    bus.loop = 1'b1;
    start_p();
    co(mk("r2_p1", E0, 0, 1, 0));
    co(mk("r2_p2", E0, 0, 1, 0));
    co(mk("r2_p3", E1, 1, 1, 0));
    co(mk("r2_p4", E2, 2, 1, 0));
    co(mk("r2_p5", E2, 2, 1, 0));
    co(mk("r2_p6", E2, 2, 1, 0));
`ifdef WAVESEQ_LOOP_EN
    co(mk("r2_p7_wrap", E0, 0, 1, 0));
    stop_p(mk("r2_stop", E0, 0, 0, 0));
`else
    co(mk("r2_p7_end", E2, 2, 0, 1));
    exp_done++;
    stop_p(mk("r2_stop_idle", E2, 2, 0, 0));
`endif
    bus.loop = 1'b0;
    settle();
    chk("r2_done_pulses", done_cnt, exp_done);

    // write during RUN is dropped; stop at entry 1 holds its selects
    start_p();
    co(mk("r3_p1", E0, 0, 1, 0));
    wr(3'd1, E1B);
    co(mk("r3_p2", E0, 0, 1, 0));
    co(mk("r3_p3_orig_e1", E1, 1, 1, 0));
    stop_p(mk("r3_stop", E1, 1, 0, 0));
    settle();
    chk("r3_no_done", done_cnt, exp_done);

    // dwell 0 entry, last_idx 1; start and cnt_co together only arm
    wr(3'd1, E1Z);
    bus.last_idx = 3'd1;
    @(posedge clk); #2;
    sb.push_back(mk("r4_arm_only", E1, 1, 1, 0));
    bus.start = 1'b1; bus.cnt_co = 1'b1;
    @(posedge clk); #2 bus.cnt_co = 1'b0;
    co(mk("r4_p1", E0, 0, 1, 0));
    bus.start = 1'b0;
    co(mk("r4_p2", E0, 0, 1, 0));
    co(mk("r4_p3_dwell0", E1Z, 1, 1, 0));
    co(mk("r4_p4_end", E1Z, 1, 0, 1));
    exp_done++;
    settle();
    chk("r4_done_pulses", done_cnt, exp_done);

    // asynchronous reset mid-run at entry 2
    bus.last_idx = 3'd2;
    start_p();
    co(mk("r5_p1", E0, 0, 1, 0));
    co(mk("r5_p2", E0, 0, 1, 0));
    co(mk("r5_p3", E1Z, 1, 1, 0));
    co(mk("r5_p4", E2, 2, 1, 0));
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", {bus.phase_sel, bus.amplitude_sel, bus.freq_sel, bus.wave_sel}, 0);
    chk("async_rst_status", {bus.busy, bus.cur_idx, bus.done}, 0);
    @(posedge clk); #2 rst = 1'b0;

    // table cleared by reset: entries read back as zero, dwell 0 acts as 1
    start_p();
    co(mk("r6_p1_cleared", ZERO, 0, 1, 0));
    co(mk("r6_p2_cleared", ZERO, 1, 1, 0));
    stop_p(mk("r6_stop", ZERO, 1, 0, 0));
    settle();
    chk("final_done_pulses", done_cnt, exp_done);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
